lfsr_engine: RTL and testbench

LFSR_ENGINE -- requirements
Module: lfsr_engine

---
 rtl/lfsr_engine.sv | 187 ++++++++++++++++++
 tb/tb_lfsr_engine.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_engine.sv
// -----------------------------------------------------------------------------
// lfsr_engine
//   N-bit LFSR with a built-in period checker. A seed is loaded while idle;
//   start snapshots the current register as the reference and enters RUN.
//   Each enabled step advances the register and counts. The run finishes once
//   2^N-1 steps have been taken. If the reference value comes back earlier,
//   the run finishes with period_err set.
//
//   Parameters
//     N     register width, 2..16
//     MODE  0 = Fibonacci, 1 = Galois
//     TAPS  user tap mask; 0 selects the built-in table (N <= 8 only)
//
//   Optional feature
//     LFSR_LOCKUP_GUARD_EN : when defined, the all-zero lock-up state cannot
//     persist. A seed of 0 loads 1, and a zero register steps to 1.
//
//   Ports
//     clk         sole clock, rising edge
//     reset       synchronous, active-high
//     load_seed   load seed_data (IDLE/DONE only), clears step_count
//     seed_data   seed value
//     start       begin a run from IDLE (load_seed has priority)
//     step_en     advance one step this cycle while in RUN
//     ack         release DONE back to IDLE
//     lfsr_data   current register contents
//     step_count  steps taken since start
//     busy        FSM in RUN
//     lfsr_done   FSM in DONE
//     period_err  sticky: reference seed reappeared before 2^N-1 steps
// -----------------------------------------------------------------------------
module lfsr_engine #(
  parameter int            N    = 4,
  parameter int            MODE = 0,
  parameter logic [N-1:0]  TAPS = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_seed,
  input  logic [N-1:0] seed_data,
  input  logic         start,
  input  logic         step_en,
  input  logic         ack,
  output logic [N-1:0] lfsr_data,
  output logic [N-1:0] step_count,
  output logic         busy,
  output logic         lfsr_done,
  output logic         period_err
);

  // Maximal-length tap masks for the widths that have a built-in entry.
  function automatic logic [15:0] table_mask(input int n);
    case (n)
      2:       return 16'b0000_0000_0000_0011;
      3:       return 16'b0000_0000_0000_0110;
      4:       return 16'b0000_0000_0000_1100;
      5:       return 16'b0000_0000_0001_0100;
      6:       return 16'b0000_0000_0011_0000;
      7:       return 16'b0000_0000_0110_0000;
      8:       return 16'b0000_0000_1011_1000;
      default: return 16'b0;
    endcase
  endfunction

  // Elaboration-time sanity checks on the configuration.
  if (N < 2 || N > 16) begin : g_bad_width
    $error("lfsr_engine: N=%0d outside 2..16", N);
  end
  if (N > 8 && TAPS == '0) begin : g_no_table
    $error("lfsr_engine: N=%0d has no built-in taps, TAPS must be nonzero", N);
  end
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("lfsr_engine: MODE=%0d must be 0 or 1", MODE);
  end

  localparam logic [15:0]  TBL      = table_mask(N);
  localparam logic [N-1:0] MASK     = (TAPS != '0) ? TAPS : TBL[N-1:0];
  localparam logic [N-1:0] ALL_ONES = '1;
  localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One LFSR step of the configured flavour.
  function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] s);
    logic [N-1:0] n;
    if (MODE == 0) n = {s[N-2:0], ^(s & MASK)};
    else           n = (s >> 1) ^ (s[0] ? MASK : '0);
`ifdef LFSR_LOCKUP_GUARD_EN
    // Zero is a fixed point of both forms; kick it out to 1.
    if (s == '0) n = ONE;
`endif
    return n;
  endfunction

  state_t       state_q, state_d;
  logic [N-1:0] lfsr_q,  lfsr_d;
  logic [N-1:0] cnt_q,   cnt_d;
  logic [N-1:0] ref_q,   ref_d;
  logic         err_q,   err_d;

  logic [N-1:0] step_val;
  logic [N-1:0] cnt_inc;
  logic [N-1:0] seed_val;

  always_comb begin
    step_val = lfsr_next(lfsr_q);
    cnt_inc  = cnt_q + ONE;
`ifdef LFSR_LOCKUP_GUARD_EN
    seed_val = (seed_data == '0) ? ONE : seed_data;
`else
    seed_val = seed_data;
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (load_seed) begin
          lfsr_d = seed_val;
          cnt_d  = '0;
        end else if (start) begin
          // The register as it stands becomes the reference for the period.
          ref_d   = lfsr_q;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (step_en) begin
          lfsr_d = step_val;
          cnt_d  = cnt_inc;
          // Reaching the full count is a clean finish even when the value
          // has wrapped back to the reference on that same step.
          if (cnt_inc == ALL_ONES) begin
            state_d = DONE;
          end else if (step_val == ref_q) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (load_seed) begin
          lfsr_d = seed_val;
          cnt_d  = '0;
        end
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lfsr_q  <= '0;
      cnt_q   <= '0;
      ref_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      err_q   <= err_d;
    end
  end

  // Status outputs decode the state register only.
  assign lfsr_data  = lfsr_q;
  assign step_count = cnt_q;
  assign period_err = err_q;
  assign busy       = (state_q == RUN);
  assign lfsr_done  = (state_q == DONE);

endmodule

// File: tb/tb_lfsr_engine.sv
// -----------------------------------------------------------------------------
// tb_lfsr_engine
//   Three 4-bit engines share one input set: Fibonacci with table taps,
//   Galois with table taps, and Fibonacci with user taps 1000 (period 4 from
//   seed 0001). The reference model derives sequences and periods from the
//   stepping rules with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_lfsr_engine;

  logic       clk = 1'b0;
  logic       reset, load_seed, start, step_en, ack;
  logic [3:0] seed_data;

  logic [3:0] lf  [3];
  logic [3:0] sc  [3];
  logic       bs  [3];
  logic       dn  [3];
  logic       pe  [3];

  int nvec = 0;
  int nbad = 0;

  localparam logic [3:0] MASKS [3] = '{4'hC, 4'hC, 4'h8};
  localparam int         MODES [3] = '{0, 1, 0};

  always #5 clk = ~clk;

  lfsr_engine #(.N(4), .MODE(0), .TAPS(4'b0000)) u_fib (
    .clk(clk), .reset(reset), .load_seed(load_seed), .seed_data(seed_data),
    .start(start), .step_en(step_en), .ack(ack),
    .lfsr_data(lf[0]), .step_count(sc[0]), .busy(bs[0]), .lfsr_done(dn[0]),
    .period_err(pe[0]));

  lfsr_engine #(.N(4), .MODE(1), .TAPS(4'b0000)) u_gal (
    .clk(clk), .reset(reset), .load_seed(load_seed), .seed_data(seed_data),
    .start(start), .step_en(step_en), .ack(ack),
    .lfsr_data(lf[1]), .step_count(sc[1]), .busy(bs[1]), .lfsr_done(dn[1]),
    .period_err(pe[1]));

  lfsr_engine #(.N(4), .MODE(0), .TAPS(4'b1000)) u_tap (
    .clk(clk), .reset(reset), .load_seed(load_seed), .seed_data(seed_data),
    .start(start), .step_en(step_en), .ack(ack),
    .lfsr_data(lf[2]), .step_count(sc[2]), .busy(bs[2]), .lfsr_done(dn[2]),
    .period_err(pe[2]));

  // ---------------- reference model ----------------
  function automatic logic [3:0] mnext(int i, logic [3:0] s);
    int v;
`ifdef LFSR_LOCKUP_GUARD_EN
    if (s == 4'd0) return 4'd1;
`endif
    if (MODES[i] == 0) v = (int'(s) * 2) % 16 + ($countones(s & MASKS[i]) % 2);
    else               v = (int'(s) / 2) ^ ((int'(s) % 2 == 1) ? int'(MASKS[i]) : 0);
    return 4'(v);
  endfunction

  function automatic logic [3:0] mval(int i, logic [3:0] seed, int k);
    logic [3:0] s = seed;
    for (int j = 0; j < k; j++) s = mnext(i, s);
    return s;
  endfunction

  // Steps until the run ends: first return to the seed, capped at 15.
  function automatic int mper(int i, logic [3:0] seed);
    logic [3:0] s = seed;
    for (int k = 1; k <= 15; k++) begin
      s = mnext(i, s);
      if (s == seed) return k;
    end
    return 15;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(string nm, int act, int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_inst(int i, string nm, logic [3:0] elf, logic [3:0] ecnt,
                          logic ebs, logic edn, logic epe);
    chk($sformatf("%s.u%0d.lfsr", nm, i),  int'(lf[i]), int'(elf));
    chk($sformatf("%s.u%0d.count", nm, i), int'(sc[i]), int'(ecnt));
    chk($sformatf("%s.u%0d.busy", nm, i),  int'(bs[i]), int'(ebs));
    chk($sformatf("%s.u%0d.done", nm, i),  int'(dn[i]), int'(edn));
    chk($sformatf("%s.u%0d.err", nm, i),   int'(pe[i]), int'(epe));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(logic [3:0] v);
    load_seed = 1'b1; seed_data = v; cyc(); load_seed = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic do_ack();
    step_en = 1'b0; ack = 1'b1; cyc(); ack = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       ld;
    logic [3:0] sd;
    logic       st, en, ak;
    logic [3:0] lf, cnt;
    logic       bs, dn, pe;
  } vec_t;

  function automatic vec_t mk(logic ld, logic [3:0] sd, logic st, logic en, logic ak,
                              logic [3:0] elf, logic [3:0] ecnt,
                              logic ebs, logic edn, logic epe);
    vec_t v;
    v.ld = ld; v.sd = sd; v.st = st; v.en = en; v.ak = ak;
    v.lf = elf; v.cnt = ecnt; v.bs = ebs; v.dn = edn; v.pe = epe;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [$];
    logic [3:0] fib_seq [16];
    logic [3:0] gal_first [4];

    fib_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101,
                4'b1010, 4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100,
                4'b1000, 4'b0001};
    gal_first = '{4'b1100, 4'b0110, 4'b0011, 4'b1101};

    // Fibonacci walk: load/start priority, step_en gaps, load and start
    // ignored in RUN, full period, start ignored in DONE, load in DONE, ack.
    tbl.push_back(mk(1, 4'b0001, 0, 0, 0, 4'b0001, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0011, 1, 0, 0, 4'b0011, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 0, 0, 4'b0001, 0, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 0, 0, 4'b0001, 0, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 1, 0, 4'b0010, 1, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 0, 4'b0010, 1, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0111, 0, 1, 0, 4'b0100, 2, 1, 0, 0));
    tbl.push_back(mk(1, 4'b0111, 0, 0, 0, 4'b0100, 2, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 1, 0, 4'b1001, 3, 1, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 0, 4'b0011, 4, 1, 0, 0));
    for (int k = 5; k <= 15; k++)
      tbl.push_back(mk(0, 4'b0000, 0, 1, 0, fib_seq[k], 4'(k), k < 15, k == 15, 0));
    tbl.push_back(mk(0, 4'b0000, 1, 1, 0, 4'b0001, 15, 0, 1, 0));
    tbl.push_back(mk(1, 4'b0101, 0, 0, 0, 4'b0101, 0, 0, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 0, 0, 1, 4'b0101, 0, 0, 0, 0));

    reset = 1'b1; load_seed = 1'b0; seed_data = 4'd0;
    start = 1'b0; step_en = 1'b0; ack = 1'b0;
    cyc(); cyc();
    for (int i = 0; i < 3; i++) chk_inst(i, "reset", 0, 0, 0, 0, 0);
    reset = 1'b0;

    // ---- table ----
    foreach (tbl[n]) begin
      load_seed = tbl[n].ld; seed_data = tbl[n].sd; start = tbl[n].st;
      step_en = tbl[n].en;   ack = tbl[n].ak;
      cyc();
      chk_inst(0, $sformatf("tbl%0d", n), tbl[n].lf, tbl[n].cnt,
               tbl[n].bs, tbl[n].dn, tbl[n].pe);
    end
    load_seed = 1'b0; start = 1'b0; step_en = 1'b0; ack = 1'b0;

    // ---- Galois sequence and short user-tap period ----
    do_load(4'b0001);
    do_start();
    step_en = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      if (k <= 4) chk($sformatf("gal.step%0d", k), int'(lf[1]), int'(gal_first[k-1]));
      if (k == 4) chk_inst(2, "taps1000", 4'b0001, 4'd4, 0, 1, 1);
      if (k == 14) chk_inst(1, "gal14", mval(1, 4'b0001, 14), 4'd14, 1, 0, 0);
    end
    chk_inst(0, "fib15", 4'b0001, 4'd15, 0, 1, 0);
    chk_inst(1, "gal15", 4'b0001, 4'd15, 0, 1, 0);
    chk_inst(2, "taps_hold", 4'b0001, 4'd4, 0, 1, 1);
    do_ack();
    chk_inst(2, "taps_ack", 4'b0001, 4'd4, 0, 0, 1);

    // ---- reset in the middle of a run ----
    do_load(4'b0001);
    do_start();
    step_en = 1'b1;
    repeat (7) cyc();
    chk_inst(0, "pre_reset", fib_seq[7], 4'd7, 1, 0, 0);
    reset = 1'b1; cyc(); reset = 1'b0; step_en = 1'b0;
    for (int i = 0; i < 3; i++) chk_inst(i, "midreset", 0, 0, 0, 0, 0);
    do_load(4'b0001);
    do_start();
    step_en = 1'b1;
    repeat (14) cyc();
    chk_inst(0, "rerun14", fib_seq[14], 4'd14, 1, 0, 0);
    cyc();
    chk_inst(0, "rerun15", 4'b0001, 4'd15, 0, 1, 0);
    do_ack();

    // ---- zero seed ----
    do_load(4'b0000);
`ifdef LFSR_LOCKUP_GUARD_EN
    chk("zero.load", int'(lf[0]), 1);
    do_start();
    step_en = 1'b1;
    repeat (15) cyc();
    chk_inst(0, "zero.run", 4'b0001, 4'd15, 0, 1, 0);
`else
    chk("zero.load", int'(lf[0]), 0);
    do_start();
    step_en = 1'b1;
    cyc();
    chk_inst(0, "zero.fib", 0, 4'd1, 0, 1, 1);
    chk_inst(1, "zero.gal", 0, 4'd1, 0, 1, 1);
`endif
    do_ack();

    // ---- randomized runs against the model ----
    for (int r = 0; r < 12; r++) begin
      logic [3:0] seed;
      int p [3];
      int k, cycles, maxp, minp;
      seed = 4'($urandom_range(1, 15));
      do_load(seed);
      do_start();
      maxp = 0; minp = 99;
      for (int i = 0; i < 3; i++) begin
        p[i] = mper(i, seed);
        if (p[i] > maxp) maxp = p[i];
        if (p[i] < minp) minp = p[i];
        chk_inst(i, $sformatf("rnd%0d.start", r), seed, 0, 1, 0, 0);
      end
      k = 0; cycles = 0;
      while (k < maxp && cycles < 200) begin
        logic en;
        en = 1'($urandom_range(0, 1));
        step_en = en;
        // Stray loads only while every engine is still running, where they
        // must be ignored.
        load_seed = ($urandom_range(0, 3) == 0) && (k < minp);
        seed_data = 4'($urandom);
        cyc();
        load_seed = 1'b0;
        cycles++;
        if (en) k++;
        for (int i = 0; i < 3; i++) begin
          int kk;
          kk = (k < p[i]) ? k : p[i];
          chk_inst(i, $sformatf("rnd%0d.c%0d", r, cycles), mval(i, seed, kk), 4'(kk),
                   k < p[i], k >= p[i], (k >= p[i]) && (p[i] < 15));
        end
      end
      if (cycles >= 200) chk($sformatf("rnd%0d.timeout", r), 1, 0);
      do_ack();
      for (int i = 0; i < 3; i++)
        chk_inst(i, $sformatf("rnd%0d.ack", r), mval(i, seed, p[i]), 4'(p[i]),
                 0, 0, p[i] < 15);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
